// File: rtl/score_pkg.sv
// -----------------------------------------------------------------------------
// score_pkg
// Shared types and constants for the score display path.
//   bcd_t           : one packed-BCD digit (4 bits)
//   BCD_MAX         : largest legal BCD digit value
//   DIGITS_DEF      : default number of score digits
//   REFRESH_DIV_DEF : default dwell, in clocks, of each scanned digit
//   AN_OFF          : all anodes off (active-low), wide enough for 8 digits
// -----------------------------------------------------------------------------
package score_pkg;

   typedef logic [3:0] bcd_t;

   localparam bcd_t       BCD_MAX         = 4'd9;
   localparam int         DIGITS_DEF      = 4;
   localparam int         REFRESH_DIV_DEF = 100000;
   localparam logic [7:0] AN_OFF          = 8'hFF;

endpackage : score_pkg

// File: rtl/score_counter_if.sv
// -----------------------------------------------------------------------------
// score_counter_if
// Bundles the game-side inputs and the display-side outputs of score_counter.
//   hit       : score event level, rising edge counts one point
//   clear     : synchronous score clear, level-sensitive
//   score_bcd : packed BCD score, units digit in bits [3:0]
//   digit_bcd : BCD value of the currently scanned digit
//   an        : active-low anode selects
//   overflow  : sticky saturation flag
// Modports:
//   master : game/display side (drives hit/clear, observes outputs)
//   slave  : score_counter itself
// -----------------------------------------------------------------------------
interface score_counter_if #(
   parameter int DIGITS = 4
);
   import score_pkg::*;

   logic                  hit;
   logic                  clear;
   logic [4*DIGITS-1:0]   score_bcd;
   bcd_t                  digit_bcd;
   logic [DIGITS-1:0]     an;
   logic                  overflow;

   modport master (
      output hit,
      output clear,
      input  score_bcd,
      input  digit_bcd,
      input  an,
      input  overflow
   );

   modport slave (
      input  hit,
      input  clear,
      output score_bcd,
      output digit_bcd,
      output an,
      output overflow
   );

endinterface : score_counter_if

// File: rtl/score_counter_bcd_incrementer.sv
// -----------------------------------------------------------------------------
// bcd_incrementer
// Combinational packed-BCD +1 with ripple carry between digits.
//   bcd_in    : packed BCD value, digit 0 in bits [3:0]
//   bcd_out   : bcd_in + 1 (wraps to all zeros from all nines)
//   all_nines : bcd_in is the largest representable score
// -----------------------------------------------------------------------------
module bcd_incrementer
   import score_pkg::*;
#(
   parameter int DIGITS = DIGITS_DEF
) (
   input  logic [4*DIGITS-1:0] bcd_in,
   output logic [4*DIGITS-1:0] bcd_out,
   output logic                all_nines
);

   always_comb begin
      logic carry;
      bcd_t d;
      bcd_out   = '0;
      all_nines = 1'b1;
      carry     = 1'b1;
      d         = '0;
      for (int i = 0; i < DIGITS; i++) begin
         d = bcd_in[4*i +: 4];
         if (d != BCD_MAX) all_nines = 1'b0;
         if (carry) begin
            // Anything above 9 cannot occur in a registered score; treat it
            // like 9 so the digit still lands back in range.
            if (d >= BCD_MAX) begin
               bcd_out[4*i +: 4] = '0;
               carry             = 1'b1;
            end else begin
               bcd_out[4*i +: 4] = d + 4'd1;
               carry             = 1'b0;
            end
         end else begin
            bcd_out[4*i +: 4] = d;
         end
      end
   end

endmodule : bcd_incrementer

// File: rtl/score_counter.sv
// -----------------------------------------------------------------------------
// score_counter
// Counts rising edges of a hit level into a saturating packed-BCD score and
// time-multiplexes the digits onto a shared seven-segment bus.
// Ports:
//   clk : system clock, rising edge
//   rst : synchronous active-high reset
//   bus : score_counter_if.slave (hit, clear in; score_bcd, digit_bcd, an,
//         overflow out)
// Parameters:
//   DIGITS      : number of BCD digits, 1..8
//   REFRESH_DIV : clocks each digit stays selected, >= 1
// Build option:
//   SCORE_BLANK_EN : when defined, leading-zero digits above the units digit
//                    keep their anode dark during their scan slot.
// -----------------------------------------------------------------------------
module score_counter
   import score_pkg::*;
#(
   parameter int DIGITS      = DIGITS_DEF,
   parameter int REFRESH_DIV = REFRESH_DIV_DEF
) (
   input  logic              clk,
   input  logic              rst,
   score_counter_if.slave    bus
);

   localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

   logic [4*DIGITS-1:0] score_q;
   logic [4*DIGITS-1:0] score_inc;
   logic                all_nines;
   logic                overflow_q;
   logic                hit_q;
   logic                hit_event;
   logic [CNT_W-1:0]    cnt_q;
   logic [IDX_W-1:0]    idx_q;
   logic [DIGITS-1:0]   an_scan;
   logic [DIGITS-1:0]   an_blank;
   bcd_t                digit_sel;

   bcd_incrementer #(
      .DIGITS (DIGITS)
   ) u_inc (
      .bcd_in    (score_q),
      .bcd_out   (score_inc),
      .all_nines (all_nines)
   );

   assign hit_event = bus.hit & ~hit_q;

   // Score, overflow and edge detector. hit_q resets high so a level already
   // present at reset release is not mistaken for a new edge. hit_q keeps
   // tracking during clear, which is what makes edges inside clear vanish.
   always_ff @(posedge clk) begin
      if (rst) begin
         score_q    <= '0;
         overflow_q <= 1'b0;
         hit_q      <= 1'b1;
      end else begin
         hit_q <= bus.hit;
         if (bus.clear) begin
            score_q    <= '0;
            overflow_q <= 1'b0;
         end else if (hit_event) begin
            if (all_nines) overflow_q <= 1'b1;
            else           score_q    <= score_inc;
         end
      end
   end

   // Free-running refresh counter and digit index.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
         idx_q <= '0;
      end else if (cnt_q == CNT_LAST) begin
         cnt_q <= '0;
         idx_q <= (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
      end else begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

   // Digit mux and anode decode from the registered index.
   always_comb begin
      an_scan   = AN_OFF[DIGITS-1:0];
      digit_sel = '0;
      for (int i = 0; i < DIGITS; i++) begin
         if (idx_q == IDX_W'(i)) begin
            an_scan[i] = 1'b0;
            digit_sel  = score_q[4*i +: 4];
         end
      end
   end

`ifdef SCORE_BLANK_EN
   // Walk from the most significant digit down; a digit is blanked while it
   // and everything above it are zero. Digit 0 always stays lit.
   always_comb begin
      logic zeros_above;
      an_blank    = '0;
      zeros_above = 1'b1;
      for (int i = DIGITS - 1; i >= 0; i--) begin
         zeros_above = zeros_above & (score_q[4*i +: 4] == 4'd0);
         if (i > 0) an_blank[i] = zeros_above;
      end
   end
`else
   assign an_blank = '0;
`endif

   assign bus.score_bcd = score_q;
   assign bus.digit_bcd = digit_sel;
   assign bus.an        = an_scan | an_blank;
   assign bus.overflow  = overflow_q;

endmodule : score_counter

// File: tb/tb_score_counter.sv
// -----------------------------------------------------------------------------
// tb_score_counter
// Scoreboard bench for score_counter with DIGITS=4, REFRESH_DIV=3.
// Stimulus pushes expected observations tagged with the cycle at which they
// must hold; a monitor on the falling edge pops and compares them.
// Build with SCORE_BLANK_EN defined to exercise leading-zero blanking.
// -----------------------------------------------------------------------------
module tb_score_counter;
   import score_pkg::*;

   localparam int DIG  = 4;
   localparam int RDIV = 3;

   localparam int F_SCORE = 0;
   localparam int F_OVF   = 1;
   localparam int F_AN    = 2;
   localparam int F_DIG   = 3;

   typedef struct {
      int unsigned tgt;
      int          fld;
      logic [31:0] val;
      string       name;
   } exp_t;

   logic clk;
   logic rst;
   int unsigned cyc;
   int unsigned rc0;
   int n_run;
   int n_fail;
   exp_t sb[$];

   logic [3:0] an_tab   [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
   logic [3:0] dig_1234 [4] = '{4'd4, 4'd3, 4'd2, 4'd1};
   logic [3:0] dig_0007 [4] = '{4'd7, 4'd0, 4'd0, 4'd0};

   score_counter_if #(.DIGITS(DIG)) bus ();

   score_counter #(
      .DIGITS      (DIG),
      .REFRESH_DIV (RDIV)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   initial rc0 = 0;
   always @(posedge clk) begin
      cyc <= cyc + 1;
      // Scan phase reference: the last clock edge that saw reset.
      if (rst) rc0 <= cyc + 1;
   end

   // Monitor: compare every expectation whose cycle has come.
   always @(negedge clk) begin
      exp_t e;
      logic [31:0] act;
      while (sb.size() > 0 && sb[0].tgt <= cyc) begin
         e = sb.pop_front();
         case (e.fld)
            F_SCORE: act = 32'(bus.score_bcd);
            F_OVF:   act = 32'(bus.overflow);
            F_AN:    act = 32'(bus.an);
            default: act = 32'(bus.digit_bcd);
         endcase
         n_run++;
         if (act !== e.val) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", e.name, act, e.val, cyc);
         end
      end
   end

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic expect_v(input int dly, input int fld, input logic [31:0] v, input string nm);
      exp_t e;
      e.tgt  = cyc + dly;
      e.fld  = fld;
      e.val  = v;
      e.name = nm;
      sb.push_back(e);
   endtask

   task automatic pulse(input int n);
      for (int k = 0; k < n; k++) begin
         bus.hit = 1'b1;
         tick();
         bus.hit = 1'b0;
         tick();
      end
   endtask

   task automatic align_scan();
      while (((cyc - rc0) % (DIG * RDIV)) != 0) tick();
   endtask

   initial begin
      n_run   = 0;
      n_fail  = 0;
      rst     = 1'b1;
      bus.hit = 1'b1;
      bus.clear = 1'b0;
      tick(3);

      // Reset state
      expect_v(0, F_SCORE, 32'h0, "reset_score");
      expect_v(0, F_OVF,   32'h0, "reset_overflow");
      expect_v(0, F_AN,    32'he, "reset_an");
      expect_v(0, F_DIG,   32'h0, "reset_digit");

      // hit held high across reset release must not count
      rst = 1'b0;
      tick(2);
      expect_v(0, F_SCORE, 32'h0, "hit_across_reset");
      bus.hit = 1'b0;
      tick();

      // Ripple carry
      pulse(99);
      expect_v(0, F_SCORE, 32'h0099, "count_0099");
      bus.hit = 1'b1;
      expect_v(1, F_SCORE, 32'h0100, "carry_0100");
      tick();
      bus.hit = 1'b0;
      tick();

      // Held hit counts once
      bus.hit = 1'b1;
      expect_v(1, F_SCORE, 32'h0101, "held_first");
      tick(10);
      expect_v(0, F_SCORE, 32'h0101, "held_10");
      bus.hit = 1'b0;
      tick();

      // Same-cycle clear and edge at 0042
      bus.clear = 1'b1;
      expect_v(1, F_SCORE, 32'h0, "clear_to_0");
      tick();
      bus.clear = 1'b0;
      tick();
      pulse(42);
      expect_v(0, F_SCORE, 32'h0042, "count_0042");
      bus.clear = 1'b1;
      bus.hit   = 1'b1;
      expect_v(1, F_SCORE, 32'h0, "clear_beats_edge");
      tick();
      bus.clear = 1'b0;
      expect_v(1, F_SCORE, 32'h0, "edge_not_deferred");
      tick(3);
      bus.hit = 1'b0;
      tick();

      // Scan of 1234
      pulse(1234);
      expect_v(0, F_SCORE, 32'h1234, "count_1234");
      align_scan();
      for (int k = 0; k < DIG * RDIV; k++) begin
         expect_v(0, F_AN,  32'(an_tab[k / RDIV]),   "scan_an_1234");
         expect_v(0, F_DIG, 32'(dig_1234[k / RDIV]), "scan_digit_1234");
         tick();
      end

      // Scan of 0007 (blanking when enabled)
      bus.clear = 1'b1;
      tick();
      bus.clear = 1'b0;
      pulse(7);
      expect_v(0, F_SCORE, 32'h0007, "count_0007");
      align_scan();
      for (int k = 0; k < DIG * RDIV; k++) begin
`ifdef SCORE_BLANK_EN
         expect_v(0, F_AN, (k / RDIV == 0) ? 32'he : 32'hf, "scan_an_0007");
`else
         expect_v(0, F_AN, 32'(an_tab[k / RDIV]), "scan_an_0007");
`endif
         expect_v(0, F_DIG, 32'(dig_0007[k / RDIV]), "scan_digit_0007");
         tick();
      end

      // Saturation
      bus.clear = 1'b1;
      tick();
      bus.clear = 1'b0;
      expect_v(0, F_SCORE, 32'h0, "sat_start");
      pulse(9999);
      expect_v(0, F_SCORE, 32'h9999, "count_9999");
      expect_v(0, F_OVF,   32'h0,    "no_ovf_at_9999");
      bus.hit = 1'b1;
      expect_v(1, F_SCORE, 32'h9999, "sat_hold");
      expect_v(1, F_OVF,   32'h1,    "ovf_set");
      tick();
      bus.hit = 1'b0;
      tick();
      pulse(1);
      expect_v(0, F_OVF,   32'h1,    "ovf_sticky");
      expect_v(0, F_SCORE, 32'h9999, "sat_hold_again");
      bus.clear = 1'b1;
      expect_v(1, F_SCORE, 32'h0, "clear_after_sat");
      expect_v(1, F_OVF,   32'h0, "clear_ovf");
      tick();
      bus.clear = 1'b0;
      tick();

      // Reset mid-count and mid-scan
      pulse(5);
      expect_v(0, F_SCORE, 32'h0005, "count_0005");
      tick();
      bus.hit = 1'b1;
      rst     = 1'b1;
      expect_v(1, F_SCORE, 32'h0, "midrst_score");
      expect_v(1, F_AN,    32'he, "midrst_an");
      expect_v(1, F_DIG,   32'h0, "midrst_digit");
      tick();
      rst = 1'b0;
      expect_v(2, F_SCORE, 32'h0, "midrst_hit_held");
      tick(3);
      bus.hit = 1'b0;
      tick();

      // Drain the scoreboard with a bounded wait
      for (int k = 0; k < 20 && sb.size() > 0; k++) tick();
      if (sb.size() > 0) begin
         n_run  += sb.size();
         n_fail += sb.size();
         $display("FAIL drain: got %0d pending, expected 0", sb.size());
      end

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule : tb_score_counter

// File: doc/score_counter.md
# score_counter

Upstream stage of the score display path. Counts game hit events into a saturating packed-BCD score and time-multiplexes the digits onto a common seven-segment bus. Each cycle it presents one BCD digit to the downstream digit-to-segment decoder, plus the matching active-low anode select.

## Interface
- `DIGITS`, default 4: number of BCD digits, legal range 1–8.
- `REFRESH_DIV`, default 100000: clock cycles each digit stays selected; minimum 1.
- `clk` input 1: system clock; all logic on the rising edge.
- `rst` input 1: reset, synchronous, active-high.
- `hit` input 1: score event level from game logic, same clock domain; each rising edge adds 1.
- `clear` input 1: synchronous score clear, level-sensitive.
- `score_bcd` output 4*DIGITS: packed BCD score; digit 0 (units) in bits [3:0].
- `digit_bcd` output 4: BCD value of the currently scanned digit, sent to the decoder.
- `an` output DIGITS: anode selects, active-low, one-hot-zero.
- `overflow` output 1: sticky flag; set when an increment is attempted at the all-nines score.

## Operation
- Edge detect: register `hit_q`. An increment event occurs when `hit & ~hit_q`. `hit_q` resets to 1, so a `hit` held high through reset release does not count.
- Increment: BCD ripple add. Digit i rolls 9→0 and carries into i+1. Each digit always stays in 0–9.
- Saturation: an event at the all-nines score (9999 for DIGITS=4) leaves the score unchanged and sets `overflow`.
- `overflow` is cleared only by `clear` or `rst`.
- Priority, high to low: `rst`, then `clear`, then increment.
- If `clear` and an event occur in the same cycle, the score goes to 0 and the event is discarded (not deferred).
- `clear` held for N cycles keeps the score at 0. Edges arriving during `clear` are lost.
- Scanner: refresh counter runs 0…REFRESH_DIV-1. On the terminal count it wraps to 0 and digit index `idx` advances 0→1→…→DIGITS-1→0.
- Scanner runs freely; it is unaffected by `clear` and `hit`.
- `an = ~(1 << idx)`. `digit_bcd = score_bcd[4*idx +: 4]`. Both are combinational from registered `idx` and score.
- Reset values: score 0, `overflow` 0, `hit_q` 1, refresh counter 0, `idx` 0.
- Outputs after reset: `an` = all ones except bit 0 low; `digit_bcd` = 0.

## Timing
- Latency: an edge on `hit` at cycle t gives the updated `score_bcd` at t+1.
- `digit_bcd` follows in the same cycle as `score_bcd` if that digit is selected.
- Maximum count rate: one increment per 2 cycles (hit toggling 1,0,1,0).
- A `hit` held high for many cycles counts once.
- Digit dwell is exactly REFRESH_DIV cycles.
- With REFRESH_DIV=1, `idx` advances every cycle.
- Full scan period is DIGITS*REFRESH_DIV cycles.
- `idx` change and the `an` change are in the same cycle: no overlap of two active anodes, no cycle with all anodes off.
- Reset asserted mid-scan or mid-count: all state returns to reset values on the next edge. No partial carry survives.

## Configuration
- `SCORE_BLANK_EN` defined: leading-zero blanking.
  - Digit i > 0 has its anode forced high (off) when it and every higher digit are 0.
  - Digit 0 is never blanked.
  - Scan timing is unchanged; a blanked slot simply stays dark.
- Undefined: all DIGITS anodes are driven in turn, and zeros are displayed.

## Structure
- Shared package `score_pkg`:
  - `bcd_t` (4-bit digit typedef);
  - `BCD_MAX = 4'd9`;
  - default `DIGITS` and `REFRESH_DIV` constants;
  - the anode-off constant.
- One natural sub-module: `bcd_incrementer`. It is combinational: packed BCD in, packed BCD plus `all_nines` flag out. The `score_counter` registers its result.
- Refresh counter and scanner stay inline.

## Test plan
- Reset, then check outputs:
  - `score_bcd`=0, `overflow`=0, `an`=4'b1110, `digit_bcd`=0.
  - `hit` high across reset release → no count.
- Ripple carry:
  - Hit pulses from 0 up to 0099 → `score_bcd`=16'h0099.
  - One more pulse → 16'h0100 on the next cycle.
  - `hit` held 10 cycles → +1 only.
- Saturation:
  - Drive to 16'h9999, pulse → still 16'h9999 and `overflow`=1.
  - `clear` → 0 and `overflow`=0.
- Same-cycle `clear` and hit edge at score 16'h0042 → 16'h0000, event dropped.
- Scan with REFRESH_DIV=3, score 16'h1234:
  - `an` sequence 1110,1101,1011,0111, each held 3 cycles.
  - `digit_bcd` sequence 4,3,2,1.
- With `SCORE_BLANK_EN`, score 16'h0007:
  - `an` shows 1110, then 1111 in each other slot.
  - `digit_bcd`=7 in slot 0.
